// File: rtl/regfile_write_port.sv
// ---------------------------------------------------------------------------
// regfile_write_port
//
// Write side of a 32-entry, 64-bit register file with an architectural zero
// register at index 31 (XZR). Entries 0..30 hold real storage; index 31 has
// none, so writes to it are dropped and it always reads back as zero.
// Alongside the storage the block tracks which entries have been written
// since reset and how many writes have been accepted.
//
// Ports
//   clk           : rising-edge clock for all state
//   reset         : synchronous, active-low reset (sampled at clk rising edge)
//   RegWrite      : write strobe, sampled at the clk rising edge
//   WriteRegister : destination index 0..31 (31 = XZR, writes discarded)
//   WriteData     : 64-bit value to store
//   ReadRegister  : readback index 0..31
//   ReadData      : combinational readback of stored state (no bypass)
//   written       : bit i set once entry i has taken a write since reset
//   wr_count      : accepted writes since reset, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module regfile_write_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WriteRegister,
  input  logic [63:0] WriteData,
  input  logic [4:0]  ReadRegister,
  output logic [63:0] ReadData,
  output logic [31:0] written,
  output logic [15:0] wr_count
);

  // Storage exists only for entries 0..30.
  logic [63:0] regs [0:30];

  logic [31:0] write_enable;
  logic        write_accept;

  // 5:32 one-hot decode of the destination, gated by the strobe. Bit 31 is
  // forced low so the zero register never sees an enable; that one line is
  // what makes XZR writes disappear from storage, written and wr_count alike.
  always_comb begin
    write_enable = '0;
    if (RegWrite) begin
      write_enable[WriteRegister] = 1'b1;
    end
    write_enable[31] = 1'b0;
  end

  assign write_accept = |write_enable;

  // Register storage. Reset is checked first so a write landing on the same
  // edge as reset is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 31; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 31; i++) begin
        if (write_enable[i]) begin
          regs[i] <= WriteData;
        end
      end
    end
  end

  // Sticky per-entry written flags; bit 31 stays clear because its enable
  // can never be high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      written <= '0;
    end else begin
      written <= written | write_enable;
    end
  end

  // Accepted-write counter, held at all-ones once it gets there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (write_accept && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Read mux over stored state only. Index 31 matches no entry and falls
  // through to the zero default, which is the XZR readback.
  always_comb begin
    ReadData = '0;
    for (int i = 0; i < 31; i++) begin
      if (ReadRegister == i[4:0]) begin
        ReadData = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_port
//
// Directed bench for regfile_write_port: a vector table for single-edge
// write/readback behaviour plus hand-written sequences for reset ordering,
// same-cycle read/write, and wr_count saturation.
// ---------------------------------------------------------------------------
module tb_regfile_write_port;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister;
  logic [63:0] ReadData;
  logic [31:0] written;
  logic [15:0] wr_count;

  int total_checks;
  int bad_checks;

  typedef struct {
    logic        we;
    logic [4:0]  wr_idx;
    logic [63:0] wdata;
    logic [4:0]  rd_idx;
    logic [63:0] exp_rdata;
    logic [31:0] exp_written;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vectors [8];

  regfile_write_port dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister  (ReadRegister),
    .ReadData      (ReadData),
    .written       (written),
    .wr_count      (wr_count)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge and settle 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wr_idx,
                               input logic [63:0] wdata, input logic [4:0] rd_idx);
    RegWrite      = we;
    WriteRegister = wr_idx;
    WriteData     = wdata;
    ReadRegister  = rd_idx;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string name, input logic [63:0] exp_rdata,
                            input logic [31:0] exp_written, input logic [15:0] exp_count);
    checkOutput({name, " ReadData"}, ReadData, exp_rdata);
    checkOutput({name, " written"}, {32'h0, written}, {32'h0, exp_written});
    checkOutput({name, " wr_count"}, {48'h0, wr_count}, {48'h0, exp_count});
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    reset        = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd0);

    // Each row: drive inputs, take one edge, check outputs after the edge.
    vectors[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 5'd5,  64'hDEADBEEF_CAFEF00D, 32'h0000_0020, 16'd1};
    vectors[1] = '{1'b0, 5'd4,  64'h0,                 5'd4,  64'h0,                 32'h0000_0020, 16'd1};
    vectors[2] = '{1'b0, 5'd6,  64'h0,                 5'd6,  64'h0,                 32'h0000_0020, 16'd1};
    vectors[3] = '{1'b1, 5'd31, 64'h1,                 5'd31, 64'h0,                 32'h0000_0020, 16'd1};
    vectors[4] = '{1'b1, 5'd7,  64'h3,                 5'd7,  64'h3,                 32'h0000_00A0, 16'd2};
    vectors[5] = '{1'b0, 5'd5,  64'h1111_2222_3333_4444, 5'd5, 64'hDEADBEEF_CAFEF00D, 32'h0000_00A0, 16'd2};
    vectors[6] = '{1'b1, 5'd0,  64'h1234,              5'd0,  64'h1234,              32'h0000_00A1, 16'd3};
    vectors[7] = '{1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4000_00A1, 16'd4};

    // Reset, then every index reads zero with no flags and no count.
    doReset();
    for (int r = 0; r < 32; r++) begin
      ReadRegister = 5'(r);
      #1;
      checkOutput($sformatf("reset read %0d", r), ReadData, 64'h0);
    end
    checkOutput("reset written", {32'h0, written}, 64'h0);
    checkOutput("reset wr_count", {48'h0, wr_count}, 64'h0);

    // Table-driven single-edge vectors.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vectors[v].we, vectors[v].wr_idx, vectors[v].wdata, vectors[v].rd_idx);
      tick();
      checkState($sformatf("vec%0d", v), vectors[v].exp_rdata,
                 vectors[v].exp_written, vectors[v].exp_count);
    end

    // Same-cycle read and write of reg 7 (holding 3): old value before the
    // edge, new value after it.
    applyStimulus(1'b1, 5'd7, 64'hA5, 5'd7);
    #1;
    checkOutput("rw7 before edge", ReadData, 64'h3);
    tick();
    checkState("rw7 after edge", 64'hA5, 32'h4000_00A1, 16'd5);

    // Reset asserted between edges changes nothing until the edge.
    applyStimulus(1'b0, 5'd0, 64'h0, 5'd7);
    reset = 1'b0;
    #2;
    checkState("mid-cycle reset", 64'hA5, 32'h4000_00A1, 16'd5);

    // Reset wins over a write on the same edge.
    applyStimulus(1'b1, 5'd2, 64'hFF, 5'd2);
    tick();
    checkState("reset vs write", 64'h0, 32'h0, 16'd0);
    ReadRegister = 5'd7;
    #1;
    checkOutput("reset cleared reg7", ReadData, 64'h0);

    // First edge with reset released takes the write.
    reset = 1'b1;
    applyStimulus(1'b1, 5'd2, 64'hFF, 5'd2);
    tick();
    checkState("first write after reset", 64'hFF, 32'h0000_0004, 16'd1);

    // Saturation: 65537 accepted writes alternating regs 9 and 12.
    doReset();
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? 5'd9 : 5'd12, 64'(i), 5'd9);
      tick();
      if (i == 65533) begin
        checkOutput("count at 65534", {48'h0, wr_count}, 64'hFFFE);
      end
      if (i == 65534) begin
        checkOutput("count at 65535", {48'h0, wr_count}, 64'hFFFF);
      end
    end
    checkState("saturated", 64'd65536, 32'h0000_1200, 16'hFFFF);
    applyStimulus(1'b1, 5'd12, 64'h77, 5'd12);
    tick();
    checkState("saturation holds", 64'h77, 32'h0000_1200, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_port.md
REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port reset, input, 1 bit: synchronous, active-low; 0 sampled at a clk rising edge resets all state.
REQ-004 Port RegWrite, input, 1 bit: write strobe, sampled at the clk rising edge.
REQ-005 Port WriteRegister, input, 5 bits: destination register index, 0..31.
REQ-006 Port WriteData, input, 64 bits: value to store.
REQ-007 Port ReadRegister, input, 5 bits: readback index.
REQ-008 Port ReadData, output, 64 bits: readback value.
REQ-009 Port written, output, 32 bits: bit i = 1 when register i has been written since reset.
REQ-010 Port wr_count, output, 16 bits: count of accepted writes since reset.

Function
REQ-011 The block SHALL decode WriteRegister into 32 one-hot enables gated by RegWrite: 5:32 decoder, the inverse of the read-select mux tree.
REQ-012 Registers 0..30 SHALL each be 64-bit; register i SHALL load WriteData at the clk edge when RegWrite=1 and WriteRegister=i; otherwise it holds.
REQ-013 Register 31 (XZR) SHALL have no storage; a write to index 31 SHALL be discarded and ReadData SHALL be 0 when ReadRegister=31.
REQ-014 ReadData SHALL be combinational from stored state: mux of the 32 registers by ReadRegister, no write-to-read bypass.
REQ-015 A read and a write to the same index in one cycle SHALL return the old value until the edge and the new value after it.
REQ-016 An accepted write SHALL be RegWrite=1 with WriteRegister != 31; only accepted writes SHALL set written[WriteRegister] and increment wr_count.
REQ-017 written[31] SHALL remain 0.
REQ-018 wr_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-019 Write latency SHALL be one edge: data written at edge N SHALL be visible on ReadData immediately after edge N.
REQ-020 With RegWrite=0, WriteRegister and WriteData SHALL be don't-care and no state SHALL change.

Reset
REQ-021 At a clk edge with reset=0, registers 0..30 SHALL become 64'h0, written SHALL become 32'h0, and wr_count SHALL become 16'h0.
REQ-022 Reset SHALL take priority over a write on the same edge; that write is lost and is not counted.
REQ-023 reset asserted between edges SHALL have no effect until the next clk rising edge, because reset is synchronous.
REQ-024 After reset is released, the first write SHALL be accepted on the first edge where reset=1.

Verification
REQ-025 Reset, then read every index 0..31 -> ReadData=0, written=32'h0, wr_count=0.
REQ-026 Write 64'hDEADBEEF_CAFEF00D to reg 5, then read 5 -> that value; written=32'h0000_0020; wr_count=1; reg 4 and reg 6 read 0.
REQ-027 Write 64'h1 to reg 31 -> ReadData(31)=0, written[31]=0, wr_count unchanged.
REQ-028 In one cycle, ReadRegister=7 and a write of 64'hA5 to reg 7, where reg 7 held 64'h3 -> ReadData=64'h3 before the edge and 64'hA5 after it.
REQ-029 Reset=0 on the same edge as a write of 64'hFF to reg 2 -> reg 2 reads 0, written=0, wr_count=0.
REQ-030 Issue 65537 accepted writes -> wr_count=16'hFFFF and holds there; written bits set only for the indices written.
